rd_txn_tracker: RTL and testbench

// Read-channel counterpart of the write transaction manager in the AXI monitor.

---
 rtl/rd_txn_tracker_if.sv | 35 +++
 rtl/rd_txn_tracker.sv | 239 +++++++++++++++++++++++
 tb/tb_rd_txn_tracker.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_txn_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : rd_txn_tracker_if
// Brief    : AR/R handshake bundle observed by the read transaction tracker.
// Revision : 1.0
// ============================================================================
interface rd_txn_tracker_if #(
  parameter int ID_WIDTH = 4
) ();
  logic                ar_valid;
  logic                ar_ready;
  logic [ID_WIDTH-1:0] ar_id;
  logic [7:0]          ar_len;
  logic                r_valid;
  logic                r_ready;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_last;

  modport master (
    output ar_valid, ar_id, ar_len, r_ready,
    input  ar_ready, r_valid, r_id, r_last
  );

  modport slave (
    input  ar_valid, ar_id, ar_len, r_ready,
    output ar_ready, r_valid, r_id, r_last
  );

  // The tracker only observes both directions of the channel.
  modport monitor (
    input ar_valid, ar_ready, ar_id, ar_len,
    input r_valid, r_ready, r_id, r_last
  );
endinterface
`default_nettype wire

// File: rtl/rd_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rd_txn_tracker
// Brief    : Tracks outstanding AXI reads with timeout budgets; define
//            RD_LAST_CHECK_EN to enable the burst-length check.
// Revision : 1.0
// ============================================================================
module rd_txn_tracker #(
  parameter int MAX_RD_TXNS   = 8,
  parameter int PRESCALER_DIV = 1,
  parameter int FIXED_BUDGET  = 2,
  parameter int CNT_WIDTH     = 10,
  parameter int ID_WIDTH      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rd_txn_tracker_if.monitor    bus,
  input  logic                 tick_i,
  input  logic                 irq_clr_i,
  output logic                 full_o,
  output logic                 timeout_o,
  output logic                 reset_req_o,
  output logic                 irq_o,
  output logic [2:0]           irq_cause_o,
  output logic [ID_WIDTH-1:0]  irq_id_o,
  output logic [CNT_WIDTH-1:0] latency_o,
  output logic                 latency_valid_o
);

  localparam int          N            = MAX_RD_TXNS;
  localparam int          IDX_W        = $clog2(N);
  localparam int          PS_SHIFT     = $clog2(PRESCALER_DIV);
  localparam logic [31:0] C_BUDGET_MAX = (32'd1 << CNT_WIDTH) - 32'd1;

  // Entry table
  logic [N-1:0]         valid_q, valid_d;
  logic [ID_WIDTH-1:0]  id_q     [N];
  logic [ID_WIDTH-1:0]  id_d     [N];
  logic [CNT_WIDTH-1:0] budget_q [N];
  logic [CNT_WIDTH-1:0] budget_d [N];
  // age_q[i][j] set means entry i was allocated before entry j
  logic [N-1:0]         age_q    [N];
  logic [N-1:0]         age_d    [N];
`ifdef RD_LAST_CHECK_EN
  logic [7:0]           len_q    [N];
  logic [7:0]           len_d    [N];
  logic [7:0]           beats_q  [N];
  logic [7:0]           beats_d  [N];
`endif

  logic                 irq_q, irq_d;
  logic [2:0]           cause_q, cause_d;
  logic [ID_WIDTH-1:0]  irq_id_q, irq_id_d;
  logic [CNT_WIDTH-1:0] latency_q, latency_d;
  logic                 lat_valid_q, lat_valid_d;

  logic                 w_full;
  logic                 w_free_found;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_timeout;
  logic [IDX_W-1:0]     w_to_idx;
  logic [N-1:0]         w_match;
  logic [N-1:0]         w_oldest;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_rbeat;
  logic                 w_unwanted;
  logic                 w_len_err;
  logic                 w_reset_req;
  logic                 w_alloc;
  logic                 w_retire;
  logic [31:0]          w_budget_sum;
  logic [CNT_WIDTH-1:0] w_budget_new;
  logic [2:0]           w_fault_cause;
  logic [ID_WIDTH-1:0]  w_fault_id;
  logic                 w_irq_base;
  logic [2:0]           w_cause_base;

  // Free-slot search, timeout detection and oldest-match selection.
  always_comb begin
    w_full       = &valid_q;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_timeout    = 1'b0;
    w_to_idx     = '0;
    w_match      = '0;
    w_oldest     = '0;
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && (budget_q[i] == '0)) begin
        w_timeout = 1'b1;
        w_to_idx  = IDX_W'(i);
      end
      w_match[i] = valid_q[i] && (id_q[i] == bus.r_id);
    end
    for (int i = 0; i < N; i++) begin
      w_oldest[i] = w_match[i];
      for (int j = 0; j < N; j++) begin
        if (w_match[j] && age_q[j][i]) w_oldest[i] = 1'b0;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (w_oldest[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_budget_sum = ({24'd0, bus.ar_len} >> PS_SHIFT) + 32'(FIXED_BUDGET);
    w_budget_new = (w_budget_sum > C_BUDGET_MAX) ? C_BUDGET_MAX[CNT_WIDTH-1:0]
                                                 : w_budget_sum[CNT_WIDTH-1:0];
  end

  // A timeout anywhere in the table swallows the R beat of that cycle.
  always_comb begin
    w_rbeat    = bus.r_valid && bus.r_ready && !w_timeout;
    w_unwanted = w_rbeat && !w_hit;
    w_retire   = w_rbeat && w_hit && bus.r_last;
    w_alloc    = bus.ar_valid && bus.ar_ready && !w_full && w_free_found;
`ifdef RD_LAST_CHECK_EN
    w_len_err  = 1'b0;
    if (w_rbeat && w_hit) begin
      if (bus.r_last) w_len_err = (beats_q[w_hit_idx] != len_q[w_hit_idx]);
      else            w_len_err = (beats_q[w_hit_idx] >= len_q[w_hit_idx]);
    end
`else
    w_len_err  = 1'b0;
`endif
    w_reset_req   = w_timeout || w_unwanted || w_len_err;
    w_fault_cause = {w_len_err, w_unwanted, w_timeout};
    w_fault_id    = w_timeout ? id_q[w_to_idx] : bus.r_id;
  end

  // Sticky interrupt state: a clear and a fresh fault in one cycle leave the fresh fault.
  always_comb begin
    w_irq_base   = irq_clr_i ? 1'b0 : irq_q;
    w_cause_base = irq_clr_i ? 3'b000 : cause_q;
    irq_d        = w_irq_base | (|w_fault_cause);
    cause_d      = w_cause_base | w_fault_cause;
    irq_id_d     = irq_clr_i ? '0 : irq_id_q;
    if ((|w_fault_cause) && !w_irq_base) irq_id_d = w_fault_id;
    latency_d    = w_retire ? budget_q[w_hit_idx] : latency_q;
    lat_valid_d  = w_retire;
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < N; i++) begin
      id_d[i]     = id_q[i];
      budget_d[i] = budget_q[i];
      age_d[i]    = age_q[i];
`ifdef RD_LAST_CHECK_EN
      len_d[i]    = len_q[i];
      beats_d[i]  = beats_q[i];
`endif
    end
    if (w_reset_req) begin
      valid_d = '0;
    end else begin
      if (tick_i) begin
        for (int i = 0; i < N; i++) begin
          if (valid_q[i] && (budget_q[i] != '0)) budget_d[i] = budget_q[i] - CNT_WIDTH'(1);
        end
      end
      if (w_rbeat && w_hit) begin
`ifdef RD_LAST_CHECK_EN
        beats_d[w_hit_idx] = beats_q[w_hit_idx] + 8'd1;
`endif
        if (bus.r_last) valid_d[w_hit_idx] = 1'b0;
      end
      // Target comes from registered state, so a slot retiring now is not reused until next cycle.
      if (w_alloc) begin
        valid_d[w_free_idx]  = 1'b1;
        id_d[w_free_idx]     = bus.ar_id;
        budget_d[w_free_idx] = w_budget_new;
`ifdef RD_LAST_CHECK_EN
        len_d[w_free_idx]    = bus.ar_len;
        beats_d[w_free_idx]  = 8'd0;
`endif
        for (int j = 0; j < N; j++) age_d[j][w_free_idx] = valid_q[j];
        age_d[w_free_idx] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        id_q[i]     <= '0;
        budget_q[i] <= '0;
        age_q[i]    <= '0;
`ifdef RD_LAST_CHECK_EN
        len_q[i]    <= '0;
        beats_q[i]  <= '0;
`endif
      end
      irq_q       <= 1'b0;
      cause_q     <= 3'b000;
      irq_id_q    <= '0;
      latency_q   <= '0;
      lat_valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) begin
        id_q[i]     <= id_d[i];
        budget_q[i] <= budget_d[i];
        age_q[i]    <= age_d[i];
`ifdef RD_LAST_CHECK_EN
        len_q[i]    <= len_d[i];
        beats_q[i]  <= beats_d[i];
`endif
      end
      irq_q       <= irq_d;
      cause_q     <= cause_d;
      irq_id_q    <= irq_id_d;
      latency_q   <= latency_d;
      lat_valid_q <= lat_valid_d;
    end
  end

  assign full_o          = w_full;
  assign timeout_o       = w_timeout;
  assign reset_req_o     = w_reset_req;
  assign irq_o           = irq_q;
  assign irq_cause_o     = cause_q;
  assign irq_id_o        = irq_id_q;
  assign latency_o       = latency_q;
  assign latency_valid_o = lat_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_txn_tracker
// Brief    : Directed scenarios plus a randomized run against a table model.
// Revision : 1.0
// ============================================================================
module tb_rd_txn_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       irq_clr;
  logic       full_o, timeout_o, reset_req_o, irq_o, latency_valid_o;
  logic [2:0] irq_cause_o;
  logic [3:0] irq_id_o;
  logic [9:0] latency_o;
  int         checks   = 0;
  int         failures = 0;

  rd_txn_tracker_if #(.ID_WIDTH(4)) bus ();

  rd_txn_tracker #(
    .MAX_RD_TXNS(8), .PRESCALER_DIV(1), .FIXED_BUDGET(2), .CNT_WIDTH(10), .ID_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .tick_i(tick), .irq_clr_i(irq_clr),
    .full_o(full_o), .timeout_o(timeout_o), .reset_req_o(reset_req_o), .irq_o(irq_o),
    .irq_cause_o(irq_cause_o), .irq_id_o(irq_id_o), .latency_o(latency_o),
    .latency_valid_o(latency_valid_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.ar_valid = 1'b0; bus.ar_ready = 1'b0; bus.ar_id = '0; bus.ar_len = '0;
    bus.r_valid  = 1'b0; bus.r_ready  = 1'b0; bus.r_id  = '0; bus.r_last = 1'b0;
    tick = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [7:0] len);
    bus.ar_valid = 1'b1; bus.ar_ready = 1'b1; bus.ar_id = id; bus.ar_len = len;
  endtask

  task automatic set_r(input logic [3:0] id, input logic last);
    bus.r_valid = 1'b1; bus.r_ready = 1'b1; bus.r_id = id; bus.r_last = last;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({full_o, timeout_o, reset_req_o} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got full/to/req=%b want 000", {full_o, timeout_o, reset_req_o});
    end
    checks++;
    if ({irq_o, irq_cause_o, irq_id_o} !== 8'h00) begin
      failures++; $display("FAIL reset_irq: got %b want 0", {irq_o, irq_cause_o, irq_id_o});
    end
    checks++;
    if ({latency_o, latency_valid_o} !== 11'd0) begin
      failures++; $display("FAIL reset_latency: got %0d/%b want 0/0", latency_o, latency_valid_o);
    end
    next();
  endtask

  task automatic test_read_burst();
    apply_reset();
    set_ar(4'd3, 8'd3); next();
    clear_inputs();
    for (int b = 0; b < 4; b++) begin set_r(4'd3, b == 3); next(); end
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({latency_valid_o, latency_o} !== {1'b1, 10'd5}) begin
      failures++; $display("FAIL burst_latency: got v=%b lat=%0d want v=1 lat=5", latency_valid_o, latency_o);
    end
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL burst_irq: got %b want 0", irq_o); end
    next();
    @(negedge clk);
    checks++;
    if (latency_valid_o !== 1'b0) begin failures++; $display("FAIL burst_lat_pulse: got %b want 0", latency_valid_o); end
    next();
    // Entry must be gone: another beat for id 3 is unwanted.
    set_r(4'd3, 1'b1);
    @(negedge clk);
    checks++;
    if (reset_req_o !== 1'b1) begin failures++; $display("FAIL burst_freed_req: got %b want 1", reset_req_o); end
    next(); clear_inputs();
    checks++;
    if (irq_cause_o !== 3'b010) begin failures++; $display("FAIL burst_freed_cause: got %b want 010", irq_cause_o); end
  endtask

  task automatic test_timeout();
    apply_reset();
    set_ar(4'd5, 8'd0); tick = 1'b1; next();
    bus.ar_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({timeout_o, reset_req_o} !== ((c == 3) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL timeout_cycle%0d: got to/req=%b want %b", c, {timeout_o, reset_req_o}, (c == 3) ? 2'b11 : 2'b00);
      end
      next();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({irq_o, irq_cause_o, irq_id_o, timeout_o} !== {1'b1, 3'b001, 4'd5, 1'b0}) begin
      failures++; $display("FAIL timeout_irq: got irq=%b cause=%b id=%0d to=%b want 1 001 5 0", irq_o, irq_cause_o, irq_id_o, timeout_o);
    end
    next();
  endtask

  task automatic test_unwanted_and_clear();
    apply_reset();
    set_r(4'd7, 1'b0);
    @(negedge clk);
    checks++;
    if ({reset_req_o, timeout_o, full_o} !== 3'b100) begin
      failures++; $display("FAIL unwanted_req: got req/to/full=%b want 100", {reset_req_o, timeout_o, full_o});
    end
    next(); clear_inputs();
    checks++;
    if ({irq_o, irq_cause_o, irq_id_o} !== {1'b1, 3'b010, 4'd7}) begin
      failures++; $display("FAIL unwanted_irq: got irq=%b cause=%b id=%0d want 1 010 7", irq_o, irq_cause_o, irq_id_o);
    end
    // Clear together with a new fault: the new fault is captured afresh.
    irq_clr = 1'b1; set_r(4'd4, 1'b1); next(); clear_inputs();
    checks++;
    if ({irq_o, irq_cause_o, irq_id_o} !== {1'b1, 3'b010, 4'd4}) begin
      failures++; $display("FAIL clear_vs_fault: got irq=%b cause=%b id=%0d want 1 010 4", irq_o, irq_cause_o, irq_id_o);
    end
    irq_clr = 1'b1; next(); clear_inputs();
    checks++;
    if ({irq_o, irq_cause_o, irq_id_o} !== 8'h00) begin
      failures++; $display("FAIL irq_clear: got %b want 0", {irq_o, irq_cause_o, irq_id_o});
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      set_ar(4'(i), 8'd7);
      if (i == 7) begin
        @(negedge clk);
        checks++;
        if (full_o !== 1'b0) begin failures++; $display("FAIL full_early: got %b want 0", full_o); end
      end
      next();
    end
    // Ninth AR while full, same cycle as retiring id 2.
    set_ar(4'd9, 8'd0); set_r(4'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (full_o !== 1'b1) begin failures++; $display("FAIL full_set: got %b want 1", full_o); end
    next(); clear_inputs();
    @(negedge clk);
    checks++;
    if ({full_o, latency_valid_o, latency_o} !== {1'b0, 1'b1, 10'd9}) begin
      failures++; $display("FAIL full_after_free: got full=%b v=%b lat=%0d want 0 1 9", full_o, latency_valid_o, latency_o);
    end
    next();
    set_ar(4'd9, 8'd0); next(); clear_inputs();
    @(negedge clk);
    checks++;
    if ({full_o, irq_o} !== 2'b10) begin failures++; $display("FAIL full_refill: got full/irq=%b want 10", {full_o, irq_o}); end
    next();
  endtask

  task automatic test_same_id_order();
    apply_reset();
    set_ar(4'd2, 8'd1); next();
    set_ar(4'd2, 8'd0); next();
    clear_inputs();
    set_r(4'd2, 1'b0); next();
    set_r(4'd2, 1'b1); next();
    set_r(4'd2, 1'b1);
    @(negedge clk);
    checks++;
    if ({latency_valid_o, latency_o} !== {1'b1, 10'd3}) begin
      failures++; $display("FAIL order_first: got v=%b lat=%0d want 1 3", latency_valid_o, latency_o);
    end
    next(); clear_inputs();
    @(negedge clk);
    checks++;
    if ({latency_valid_o, latency_o, irq_o} !== {1'b1, 10'd2, 1'b0}) begin
      failures++; $display("FAIL order_second: got v=%b lat=%0d irq=%b want 1 2 0", latency_valid_o, latency_o, irq_o);
    end
    next();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_ar(4'd1, 8'd0); next();
    set_ar(4'd4, 8'd2); set_r(4'd1, 1'b1); next();
    clear_inputs(); set_r(4'd4, 1'b1);
    @(negedge clk);
    checks++;
    if ({latency_valid_o, latency_o} !== {1'b1, 10'd2}) begin
      failures++; $display("FAIL b2b_retire: got v=%b lat=%0d want 1 2", latency_valid_o, latency_o);
    end
    next(); clear_inputs();
    @(negedge clk);
    checks++;
    if ({latency_valid_o, latency_o, irq_o} !== {1'b1, 10'd4, 1'b0}) begin
      failures++; $display("FAIL b2b_alloc: got v=%b lat=%0d irq=%b want 1 4 0", latency_valid_o, latency_o, irq_o);
    end
    next();
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_ar(4'd6, 8'd3); next();
    clear_inputs(); set_r(4'd6, 1'b0); next();
    clear_inputs();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    set_r(4'd6, 1'b1);
    @(negedge clk);
    checks++;
    if (reset_req_o !== 1'b1) begin failures++; $display("FAIL async_req: got %b want 1", reset_req_o); end
    next(); clear_inputs();
    checks++;
    if ({irq_cause_o, irq_id_o} !== {3'b010, 4'd6}) begin
      failures++; $display("FAIL async_cause: got cause=%b id=%0d want 010 6", irq_cause_o, irq_id_o);
    end
  endtask

`ifdef RD_LAST_CHECK_EN
  task automatic test_len_check();
    apply_reset();
    set_ar(4'd1, 8'd3); next();
    clear_inputs();
    set_r(4'd1, 1'b0); next();
    set_r(4'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (reset_req_o !== 1'b1) begin failures++; $display("FAIL lencheck_req: got %b want 1", reset_req_o); end
    next(); clear_inputs();
    checks++;
    if ({irq_cause_o, full_o} !== {3'b100, 1'b0}) begin
      failures++; $display("FAIL lencheck_cause: got cause=%b full=%b want 100 0", irq_cause_o, full_o);
    end
  endtask
`endif

  task automatic test_random();
    bit         mv [8];
    logic [3:0] mid [8];
    int         mbud [8];
    int         mseq [8];
`ifdef RD_LAST_CHECK_EN
    int         mlen [8];
    int         mbeats [8];
`endif
    int         seqc, tidx, m, k, rfails, m_lat;
    bit         m_irq, m_latv, e_full, e_to, e_req, rbeat, unw, lerr, alloc;
    logic [2:0] m_cause, fc;
    logic [3:0] m_id, fid;
    apply_reset();
    seqc = 0; rfails = 0; m_lat = 0; m_irq = 0; m_latv = 0; m_cause = '0; m_id = '0;
    for (int i = 0; i < 8; i++) begin mv[i] = 0; mid[i] = '0; mbud[i] = 0; mseq[i] = 0; end
    for (int cyc = 0; cyc < 3000 && rfails < 10; cyc++) begin
      bus.ar_valid = ($urandom_range(0, 2) == 0);
      bus.ar_ready = ($urandom_range(0, 3) != 0);
      bus.ar_id    = 4'($urandom_range(0, 3));
      bus.ar_len   = 8'($urandom_range(0, 7));
      bus.r_valid  = ($urandom_range(0, 1) == 1);
      bus.r_ready  = ($urandom_range(0, 3) != 0);
      bus.r_id     = 4'($urandom_range(0, 3));
      bus.r_last   = ($urandom_range(0, 2) == 0);
      tick         = ($urandom_range(0, 5) == 0);
      irq_clr      = ($urandom_range(0, 24) == 0);
      e_full = 1; e_to = 0; tidx = -1; m = -1; k = -1;
      for (int i = 0; i < 8; i++) begin
        if (!mv[i]) begin e_full = 0; if (k < 0) k = i; end
        if (mv[i] && mbud[i] == 0 && tidx < 0) begin e_to = 1; tidx = i; end
        if (mv[i] && mid[i] == bus.r_id && (m < 0 || mseq[i] < mseq[m])) m = i;
      end
      rbeat = bus.r_valid && bus.r_ready && !e_to;
      unw   = rbeat && (m < 0);
      lerr  = 0;
`ifdef RD_LAST_CHECK_EN
      if (rbeat && m >= 0) lerr = bus.r_last ? (mbeats[m] != mlen[m]) : (mbeats[m] >= mlen[m]);
`endif
      e_req = e_to || unw || lerr;
      alloc = bus.ar_valid && bus.ar_ready && !e_full;
      @(negedge clk);
      checks++;
      if ({full_o, timeout_o, reset_req_o} !== {e_full, e_to, e_req}) begin
        failures++; rfails++;
        $display("FAIL rand_comb cyc=%0d: got full/to/req=%b want %b", cyc, {full_o, timeout_o, reset_req_o}, {e_full, e_to, e_req});
      end
      checks++;
      if ({irq_o, irq_cause_o, irq_id_o, latency_o, latency_valid_o} !== {m_irq, m_cause, m_id, 10'(m_lat), m_latv}) begin
        failures++; rfails++;
        $display("FAIL rand_regs cyc=%0d: got irq=%b cause=%b id=%0d lat=%0d v=%b want %b %b %0d %0d %b",
                 cyc, irq_o, irq_cause_o, irq_id_o, latency_o, latency_valid_o, m_irq, m_cause, m_id, m_lat, m_latv);
      end
      fc  = {lerr, unw, e_to};
      fid = bus.r_id;
      if (e_to) fid = mid[tidx];
      if (irq_clr) begin m_irq = 0; m_cause = '0; m_id = '0; end
      if (fc != 3'b000) begin
        if (!m_irq) m_id = fid;
        m_irq = 1; m_cause = m_cause | fc;
      end
      m_latv = rbeat && (m >= 0) && bus.r_last;
      if (m_latv) m_lat = mbud[m];
      if (e_req) begin
        for (int i = 0; i < 8; i++) mv[i] = 0;
      end else begin
        if (tick) for (int i = 0; i < 8; i++) if (mv[i] && mbud[i] > 0) mbud[i]--;
        if (rbeat && m >= 0) begin
`ifdef RD_LAST_CHECK_EN
          mbeats[m]++;
`endif
          if (bus.r_last) mv[m] = 0;
        end
        if (alloc) begin
          mv[k] = 1; mid[k] = bus.ar_id; mseq[k] = seqc; seqc++;
          mbud[k] = (int'(bus.ar_len) + 2 > 1023) ? 1023 : int'(bus.ar_len) + 2;
`ifdef RD_LAST_CHECK_EN
          mlen[k] = int'(bus.ar_len); mbeats[k] = 0;
`endif
        end
      end
      next();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_read_burst();
    test_timeout();
    test_unwanted_and_clear();
    test_full();
    test_same_id_order();
    test_back_to_back();
    test_async_reset();
`ifdef RD_LAST_CHECK_EN
    test_len_check();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
